// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic M_INSTR = 1'b0;
    localparam logic M_DATA  = 1'b1;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/instr_data_mem_arbiter_if.sv
// Bundles the two requester ports and the shared memory port.
// master: requesters plus memory side; slave: the arbiter itself.
interface instr_data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_we;
    logic [3:0]        m1_be;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output m0_req, m0_addr,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_we, m1_be, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  m0_req, m0_addr,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_we, m1_be, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin chooser: on a tie the master that was not served last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       res,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       win,
    output logic [1:0] sel
);

    logic rr_last_reg;

    // rr_last resets to 1 so master 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (!res) begin
            rr_last_reg <= 1'b1;
        end else if (upd) begin
            rr_last_reg <= win;
        end
    end

    always_comb begin
        sel = 2'b00;
        case (req)
            2'b01:   sel = 2'b01;
            2'b10:   sel = 2'b10;
            2'b11:   sel = rr_last_reg ? 2'b01 : 2'b10;
            default: sel = 2'b00;
        endcase
    end

endmodule

// File: rtl/instr_data_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between I-cache refill (m0) and CPU data (m1),
// one transaction in flight, with a response watchdog that answers ERR_DATA.
module instr_data_mem_arbiter
    import arb_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(DEFAULT_ERR_DATA)
) (
    input  logic                     clk,
    input  logic                     res,
    instr_data_mem_arbiter_if.slave  bus,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              timeout_err_reg;
    logic              err_set;
    logic [1:0]        req_vec;
    logic [1:0]        sel_onehot;
    logic              arb_upd;
    logic              cur_idx;
    logic              drive_en;
    logic              mem_req_c;
    logic              gnt_en;
    logic              rvalid_en;
    logic [DATA_W-1:0] rdata_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic              we_mux;
    logic [3:0]        be_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              gnt_vec    [2];
    logic              rvalid_vec [2];
    logic [DATA_W-1:0] rdata_vec  [2];

    assign req_vec = {bus.m1_req, bus.m0_req};

    rr_arbiter2 u_rr (
        .clk (clk),
        .res (res),
        .req (req_vec),
        .upd (arb_upd),
        .win (cur_idx),
        .sel (sel_onehot)
    );

    always_ff @(posedge clk) begin
        if (!res) begin
            state_reg       <= IDLE;
            owner_reg       <= M_INSTR;
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
            if (err_set) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        err_set    = 1'b0;
        arb_upd    = 1'b0;
        cur_idx    = owner_reg;
        drive_en   = 1'b0;
        mem_req_c  = 1'b0;
        gnt_en     = 1'b0;
        rvalid_en  = 1'b0;
        rdata_mux  = '0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                cur_idx  = sel_onehot[1];
                if (|sel_onehot) begin
                    drive_en   = 1'b1;
                    mem_req_c  = 1'b1;
                    gnt_en     = bus.mem_gnt;
                    owner_next = cur_idx;
                    if (bus.mem_gnt) begin
                        state_next = RESP;
                        arb_upd    = 1'b1;
                    end else begin
                        state_next = ADDR;
                    end
                end
            end
            ADDR: begin
                // Locked to the owner; a dropped req abandons the attempt.
                drive_en  = 1'b1;
                mem_req_c = req_vec[owner_reg];
                if (!req_vec[owner_reg]) begin
                    state_next = IDLE;
                end else if (bus.mem_gnt) begin
                    gnt_en     = 1'b1;
                    arb_upd    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.mem_rvalid) begin
                    rvalid_en  = 1'b1;
                    rdata_mux  = bus.mem_rdata;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    rvalid_en  = 1'b1;
                    rdata_mux  = ERR_DATA;
                    err_set    = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Instruction side is read-only: fixed we/be/wdata.
    always_comb begin
        addr_mux  = '0;
        we_mux    = 1'b0;
        be_mux    = 4'b0000;
        wdata_mux = '0;
        if (drive_en) begin
            if (cur_idx == M_DATA) begin
                addr_mux  = bus.m1_addr;
                we_mux    = bus.m1_we;
                be_mux    = bus.m1_be;
                wdata_mux = bus.m1_wdata;
            end else begin
                addr_mux = bus.m0_addr;
                be_mux   = 4'b1111;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        assign gnt_vec[gi]    = gnt_en && (cur_idx == 1'(gi));
        assign rvalid_vec[gi] = rvalid_en && (cur_idx == 1'(gi));
        assign rdata_vec[gi]  = rvalid_vec[gi] ? rdata_mux : '0;
    end

    assign bus.m0_gnt    = gnt_vec[0];
    assign bus.m0_rvalid = rvalid_vec[0];
    assign bus.m0_rdata  = rdata_vec[0];
    assign bus.m1_gnt    = gnt_vec[1];
    assign bus.m1_rvalid = rvalid_vec[1];
    assign bus.m1_rdata  = rdata_vec[1];

    assign bus.mem_req   = mem_req_c;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_we    = we_mux;
    assign bus.mem_be    = be_mux;
    assign bus.mem_wdata = wdata_mux;

    assign busy        = (state_reg != IDLE);
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_instr_data_mem_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model.
module tb_instr_data_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TO     = 8;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic busy;
    logic timeout_err;
    int   tests = 0;
    int   fails = 0;

    instr_data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_data_mem_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .res         (res),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_req     = 1'b0;
        bus.m0_addr    = '0;
        bus.m1_req     = 1'b0;
        bus.m1_addr    = '0;
        bus.m1_we      = 1'b0;
        bus.m1_be      = 4'h0;
        bus.m1_wdata   = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic pulse_reset();
        res = 1'b0;
        clear_inputs();
        step();
        step();
        res = 1'b1;
    endtask

    task automatic test_reset();
        pulse_reset();
        #1;
        tests++;
        if ({bus.m0_gnt, bus.m0_rvalid, bus.m1_gnt, bus.m1_rvalid, bus.mem_req, bus.mem_we, busy, timeout_err} !== 8'b0
            || (bus.m0_rdata | bus.m1_rdata | bus.mem_addr | bus.mem_wdata) !== 32'h0 || bus.mem_be !== 4'h0) begin
            fails++;
            $display("FAIL reset_outputs: got ctl=%b data_or=%h be=%h, want all 0",
                     {bus.m0_gnt, bus.m0_rvalid, bus.m1_gnt, bus.m1_rvalid, bus.mem_req, bus.mem_we, busy, timeout_err},
                     bus.m0_rdata | bus.m1_rdata | bus.mem_addr | bus.mem_wdata, bus.mem_be);
        end
        $display("[TB] reset: outputs idle");
        step();
    endtask

    task automatic test_single_read();
        bus.m0_req  = 1'b1;
        bus.m0_addr = 32'h100;
        bus.mem_gnt = 1'b1;
        #1;
        tests++;
        if ({bus.m0_gnt, bus.mem_req, bus.mem_we, bus.mem_be} !== 7'b1101111 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL single_issue: got gnt/req/we/be=%b addr=%h wdata=%h, want 1101111 100 0",
                     {bus.m0_gnt, bus.mem_req, bus.mem_we, bus.mem_be}, bus.mem_addr, bus.mem_wdata);
        end
        tests++;
        if ({bus.m1_gnt, bus.m1_rvalid} !== 2'b00 || bus.m1_rdata !== 32'h0) begin
            fails++;
            $display("FAIL single_m1_quiet: got gnt/rvalid=%b rdata=%h, want 00 0", {bus.m1_gnt, bus.m1_rvalid}, bus.m1_rdata);
        end
        step();
        bus.m0_req  = 1'b0;
        bus.mem_gnt = 1'b0;
        #1;
        tests++;
        if ({bus.m0_gnt, bus.mem_req, busy} !== 3'b001) begin
            fails++;
            $display("FAIL single_wait: got gnt/req/busy=%b, want 001", {bus.m0_gnt, bus.mem_req, busy});
        end
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0013;
        #1;
        tests++;
        if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b10 || bus.m0_rdata !== 32'h13 || bus.m1_rdata !== 32'h0) begin
            fails++;
            $display("FAIL single_resp: got rvalid=%b m0_rdata=%h m1_rdata=%h, want 10 00000013 0",
                     {bus.m0_rvalid, bus.m1_rvalid}, bus.m0_rdata, bus.m1_rdata);
        end
        step();
        clear_inputs();
        #1;
        tests++;
        if ({busy, bus.m0_rvalid} !== 2'b00) begin
            fails++;
            $display("FAIL single_done: got busy/rvalid=%b, want 00", {busy, bus.m0_rvalid});
        end
        $display("[TB] single read 0x100 -> 0x13");
        step();
    endtask

    task automatic test_tie_alternation();
        pulse_reset();
        bus.m0_req  = 1'b1;
        bus.m0_addr = 32'h300;
        bus.m1_req  = 1'b1;
        bus.m1_addr = 32'h200;
        bus.m1_be   = 4'hF;
        bus.mem_gnt = 1'b1;
        #1;
        tests++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10 || bus.mem_addr !== 32'h300) begin
            fails++;
            $display("FAIL tie_first: got gnt m0/m1=%b addr=%h, want 10 300", {bus.m0_gnt, bus.m1_gnt}, bus.mem_addr);
        end
        step();
        bus.m0_req     = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hA0;
        #1;
        tests++;
        if ({bus.m0_rvalid, bus.m1_rvalid, bus.m1_gnt} !== 3'b100) begin
            fails++;
            $display("FAIL tie_m0_resp: got rv0/rv1/gnt1=%b, want 100", {bus.m0_rvalid, bus.m1_rvalid, bus.m1_gnt});
        end
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b1;
        #1;
        tests++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01 || bus.mem_addr !== 32'h200) begin
            fails++;
            $display("FAIL tie_second: got gnt m0/m1=%b addr=%h, want 01 200", {bus.m0_gnt, bus.m1_gnt}, bus.mem_addr);
        end
        step();
        bus.m1_req     = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hB1;
        #1;
        tests++;
        if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b01 || bus.m1_rdata !== 32'hB1) begin
            fails++;
            $display("FAIL tie_m1_resp: got rvalid=%b rdata=%h, want 01 b1", {bus.m0_rvalid, bus.m1_rvalid}, bus.m1_rdata);
        end
        step();
        bus.mem_rvalid = 1'b0;
        bus.m0_req     = 1'b1;
        bus.m1_req     = 1'b1;
        bus.mem_gnt    = 1'b1;
        #1;
        tests++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL tie_third: got gnt m0/m1=%b, want 10", {bus.m0_gnt, bus.m1_gnt});
        end
        step();
        clear_inputs();
        bus.mem_rvalid = 1'b1;
        step();
        clear_inputs();
        $display("[TB] tie alternation m0, m1, m0");
    endtask

    task automatic test_grant_stall();
        bus.m1_req   = 1'b1;
        bus.m1_addr  = 32'h2000;
        bus.m1_we    = 1'b1;
        bus.m1_be    = 4'hF;
        bus.m1_wdata = 32'hCAFE_F00D;
        bus.mem_gnt  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                bus.m0_req  = 1'b1;
                bus.m0_addr = 32'h500;
            end
            #1;
            tests++;
            if ({bus.mem_req, bus.mem_we, bus.m0_gnt, bus.m1_gnt} !== 4'b1100 || bus.mem_addr !== 32'h2000
                || bus.mem_wdata !== 32'hCAFE_F00D) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got req/we/g0/g1=%b addr=%h wdata=%h, want 1100 2000 cafef00d",
                         c, {bus.mem_req, bus.mem_we, bus.m0_gnt, bus.m1_gnt}, bus.mem_addr, bus.mem_wdata);
            end
            step();
        end
        bus.mem_gnt = 1'b1;
        #1;
        tests++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we} !== 3'b011 || bus.mem_addr !== 32'h2000) begin
            fails++;
            $display("FAIL stall_grant: got g0/g1/we=%b addr=%h, want 011 2000", {bus.m0_gnt, bus.m1_gnt, bus.mem_we}, bus.mem_addr);
        end
        step();
        bus.m1_req     = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h600D;
        #1;
        tests++;
        if ({bus.m1_rvalid, bus.m0_rvalid, bus.m0_gnt, bus.mem_req} !== 4'b1000) begin
            fails++;
            $display("FAIL stall_m1_resp: got rv1/rv0/g0/req=%b, want 1000", {bus.m1_rvalid, bus.m0_rvalid, bus.m0_gnt, bus.mem_req});
        end
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b1;
        #1;
        tests++;
        if ({bus.m0_gnt, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h500) begin
            fails++;
            $display("FAIL stall_m0_after: got g0/we=%b addr=%h, want 10 500", {bus.m0_gnt, bus.mem_we}, bus.mem_addr);
        end
        step();
        clear_inputs();
        bus.mem_rvalid = 1'b1;
        step();
        clear_inputs();
        $display("[TB] grant stall on m1 write 0x2000");
    endtask

    task automatic test_timeout();
        bus.m0_req  = 1'b1;
        bus.m0_addr = 32'h400;
        bus.mem_gnt = 1'b1;
        step();
        clear_inputs();
        for (int k = 1; k <= TO; k++) begin
            #1;
            tests++;
            if ({bus.m0_rvalid, timeout_err} !== {(k == TO), 1'b0} || (k == TO && bus.m0_rdata !== 32'hDEAD_BEEF)) begin
                fails++;
                $display("FAIL timeout_cycle[%0d]: got rvalid/err=%b rdata=%h, want %b deadbeef-on-last",
                         k, {bus.m0_rvalid, timeout_err}, bus.m0_rdata, {(k == TO), 1'b0});
            end
            step();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77;
        #1;
        tests++;
        if ({busy, timeout_err, bus.m0_rvalid, bus.m1_rvalid} !== 4'b0100) begin
            fails++;
            $display("FAIL timeout_after: got busy/err/rv0/rv1=%b, want 0100", {busy, timeout_err, bus.m0_rvalid, bus.m1_rvalid});
        end
        step();
        clear_inputs();
        #1;
        tests++;
        if (timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: got %b, want 1", timeout_err);
        end
        $display("[TB] timeout after %0d RESP cycles", TO);
        step();
    endtask

    task automatic test_coincident();
        pulse_reset();
        bus.m0_req  = 1'b1;
        bus.m0_addr = 32'h440;
        bus.mem_gnt = 1'b1;
        step();
        clear_inputs();
        for (int k = 1; k <= TO; k++) begin
            if (k == TO) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'h1234_5678;
            end
            #1;
            tests++;
            if (bus.m0_rvalid !== (k == TO) || (k == TO && bus.m0_rdata !== 32'h1234_5678)) begin
                fails++;
                $display("FAIL coincident_cycle[%0d]: got rvalid=%b rdata=%h, want %b 12345678-on-last",
                         k, bus.m0_rvalid, bus.m0_rdata, (k == TO));
            end
            step();
        end
        clear_inputs();
        #1;
        tests++;
        if ({timeout_err, busy} !== 2'b00) begin
            fails++;
            $display("FAIL coincident_err: got err/busy=%b, want 00", {timeout_err, busy});
        end
        $display("[TB] rvalid coincident with last timeout cycle");
        step();
    endtask

    task automatic test_reset_in_resp();
        bus.m0_req  = 1'b1;
        bus.m0_addr = 32'h800;
        bus.mem_gnt = 1'b1;
        step();
        clear_inputs();
        res = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_resp_pre: got busy=%b, want 1", busy);
        end
        step();
        res = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD;
        #1;
        tests++;
        if ({busy, bus.mem_req, bus.m0_rvalid, bus.m1_rvalid} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_resp_post: got busy/req/rv0/rv1=%b, want 0000", {busy, bus.mem_req, bus.m0_rvalid, bus.m1_rvalid});
        end
        step();
        bus.mem_rvalid = 1'b0;
        bus.m0_req     = 1'b1;
        bus.m0_addr    = 32'h880;
        bus.m1_req     = 1'b1;
        bus.m1_addr    = 32'h900;
        bus.mem_gnt    = 1'b1;
        #1;
        tests++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10 || bus.mem_addr !== 32'h880) begin
            fails++;
            $display("FAIL rst_resp_tie: got gnt m0/m1=%b addr=%h, want 10 880", {bus.m0_gnt, bus.m1_gnt}, bus.mem_addr);
        end
        step();
        clear_inputs();
        bus.mem_rvalid = 1'b1;
        step();
        clear_inputs();
        $display("[TB] reset during RESP");
    endtask

    // Model phases: 0 = arbiter free, 1 = waiting for mem_gnt, 2 = waiting for response.
    task automatic test_random();
        int          phase;
        int          owner;
        int          last;
        int          lat;
        int          w;
        bit          pend [2];
        bit          outst [2];
        logic [31:0] a [2];
        logic        we1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rdat;
        logic        g;
        logic [69:0] exp_mem;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rv;
        int          base_fails;

        pulse_reset();
        phase = 0; owner = 0; last = 1; lat = 0; rdat = '0;
        we1 = 1'b0; be1 = 4'h0; wd1 = '0;
        base_fails = fails;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; outst[m] = 1'b0; a[m] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && !outst[m] && $urandom_range(0, 2) == 0) begin
                    pend[m] = 1'b1;
                    a[m] = $urandom() & 32'hFFFF_FFFC;
                    if (m == 1) begin
                        we1 = 1'($urandom_range(0, 1));
                        be1 = 4'($urandom_range(0, 15));
                        wd1 = $urandom();
                    end
                end
            end
            g = 1'($urandom_range(0, 1));
            bus.m0_req     = pend[0];
            bus.m0_addr    = a[0];
            bus.m1_req     = pend[1];
            bus.m1_addr    = a[1];
            bus.m1_we      = we1;
            bus.m1_be      = be1;
            bus.m1_wdata   = wd1;
            bus.mem_gnt    = g;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom();
            if (phase == 2) begin
                if (lat == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdat;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.mem_rvalid = 1'b1;
            end

            w = -1;
            if (phase == 0) begin
                if (pend[0] && pend[1]) w = (last == 0) ? 1 : 0;
                else if (pend[0])       w = 0;
                else if (pend[1])       w = 1;
            end else if (phase == 1) begin
                w = owner;
            end
            if (w == 1)      exp_mem = {1'b1, we1, be1, a[1], wd1};
            else if (w == 0) exp_mem = {1'b1, 1'b0, 4'hF, a[0], 32'h0};
            else             exp_mem = '0;
            exp_gnt = (w >= 0 && g) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            exp_rv  = (phase == 2 && lat == 0) ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            #1;

            tests++;
            if (phase == 2) begin
                if (bus.mem_req !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_mem_req[%0d]: got %b, want 0", cyc, bus.mem_req);
                end
            end else if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== exp_mem) begin
                fails++;
                $display("FAIL rand_mem_bus[%0d]: got %h, want %h", cyc,
                         {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, exp_mem);
            end
            tests++;
            if ({bus.m1_gnt, bus.m0_gnt} !== exp_gnt) begin
                fails++;
                $display("FAIL rand_gnt[%0d]: got %b, want %b", cyc, {bus.m1_gnt, bus.m0_gnt}, exp_gnt);
            end
            tests++;
            if ({bus.m1_rvalid, bus.m0_rvalid} !== exp_rv
                || (exp_rv == 2'b01 && (bus.m0_rdata !== rdat || bus.m1_rdata !== 32'h0))
                || (exp_rv == 2'b10 && (bus.m1_rdata !== rdat || bus.m0_rdata !== 32'h0))) begin
                fails++;
                $display("FAIL rand_resp[%0d]: got rvalid=%b rdata0=%h rdata1=%h, want %b data %h", cyc,
                         {bus.m1_rvalid, bus.m0_rvalid}, bus.m0_rdata, bus.m1_rdata, exp_rv, rdat);
            end
            tests++;
            if (busy !== (phase != 0)) begin
                fails++;
                $display("FAIL rand_busy[%0d]: got %b, want %b", cyc, busy, (phase != 0));
            end

            case (phase)
                0, 1: begin
                    if (w >= 0) begin
                        owner = w;
                        if (g) begin
                            pend[w]  = 1'b0;
                            outst[w] = 1'b1;
                            last     = w;
                            lat      = $urandom_range(0, 3);
                            rdat     = $urandom();
                            phase    = 2;
                        end else begin
                            phase = 1;
                        end
                    end
                end
                default: begin
                    if (lat == 0) begin
                        outst[owner] = 1'b0;
                        phase = 0;
                    end else begin
                        lat--;
                    end
                end
            endcase
            step();
        end
        clear_inputs();
        $display("[TB] random: 400 cycles, %0d new failures", fails - base_fails);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_tie_alternation();
        test_grant_stall();
        test_timeout();
        test_coincident();
        test_reset_in_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_data_mem_arbiter.md
Name: instr_data_mem_arbiter

Overview:
- Shares one req/gnt/rvalid memory port between two requesters: the instruction-cache refill side (master 0) and the CPU data side (master 1).
- Sits between the cache/proc pair and the SoC memory interface. This lets a single-port memory serve both streams.
- Allows one outstanding transaction at a time.
- Arbitration is round-robin. A response-timeout watchdog returns an error word if memory never answers.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT_CYCLES, 256, maximum cycles in RESP before the watchdog fires (must be ≥2)
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
- clk  in  1  system clock; all state changes on rising edge
- res  in  1  synchronous active-low reset, sampled on rising clk
- m0_req  in  1  instruction-side request
- m0_addr  in  ADDR_W  instruction-side address
- m0_gnt  out  1  grant to master 0
- m0_rvalid  out  1  response valid to master 0
- m0_rdata  out  DATA_W  response data to master 0
- m1_req  in  1  data-side request
- m1_addr  in  ADDR_W  data-side address
- m1_we  in  1  data-side write enable
- m1_be  in  4  data-side byte enables
- m1_wdata  in  DATA_W  data-side write data
- m1_gnt  out  1  grant to master 1
- m1_rvalid  out  1  response valid to master 1
- m1_rdata  out  DATA_W  response data to master 1
- mem_req  out  1  request to memory
- mem_addr  out  ADDR_W  address to memory
- mem_we  out  1  write enable to memory; 0 for master 0
- mem_be  out  4  byte enables to memory; 4'b1111 for master 0
- mem_wdata  out  DATA_W  write data to memory; 0 for master 0
- mem_gnt  in  1  memory grant
- mem_rvalid  in  1  memory response valid; also returned for writes
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in ADDR or RESP
- timeout_err  out  1  sticky flag, set by the watchdog, cleared only by reset

Behaviour:
- Reset (res=0 at a rising edge):
  - state=IDLE, owner=0, rr_last=1 (master 0 wins the first tie), timeout counter=0, timeout_err=0.
  - All outputs are 0 while state is IDLE and no req is asserted.
  - Reset mid-transaction abandons the transaction. Any mem_rvalid arriving after reset is ignored.
- Protocol: a master holds req and its address/data stable until it sees gnt. Exactly one rvalid follows each gnt, at least 1 cycle later.
- IDLE:
  - If exactly one req is high, that master is selected. If both are high, the master ≠ rr_last is selected.
  - mem_req and address/control/data mux from the selected master combinationally, in the same cycle.
  - mx_gnt = mem_gnt for the selected master only.
  - If mem_gnt=1 → RESP, with owner latched and rr_last=selected.
  - Else → ADDR, with owner locked.
- ADDR:
  - mem_req and the mux stay on owner regardless of the other req; there is no re-arbitration.
  - On mem_gnt → RESP and rr_last=owner.
  - If owner drops req, that is a protocol violation. The arbiter keeps mem_req driven from m[owner]_req and returns to IDLE when it is 0.
- RESP:
  - mem_req=0, and both gnt outputs are 0.
  - mem_rvalid/mem_rdata route to owner. The other master's rvalid stays 0 and its rdata is 0.
  - On mem_rvalid → IDLE, with the counter cleared. The next arbitration happens in the next cycle, so back-to-back transactions have a 1-cycle bubble minimum.
  - The counter increments each RESP cycle without rvalid. When it reaches TIMEOUT_CYCLES-1 with no rvalid, the arbiter asserts m[owner]_rvalid=1 with rdata=ERR_DATA for 1 cycle, sets timeout_err, and goes → IDLE.
  - If mem_rvalid and the timeout coincide, real data wins and timeout_err is not set.
- A stray mem_rvalid seen in IDLE or ADDR is discarded.
- Counter width is clog2(TIMEOUT_CYCLES); it saturates and never wraps.
- Latency for an uncontended master with gnt in the same cycle and rvalid N cycles later: data reaches the master in the same cycle as mem_rvalid. There is no added register stage.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, ADDR, RESP}
  - master index constants M_INSTR=0, M_DATA=1
  - ERR_DATA default value
- One sub-module, rr_arbiter2: a 2-input round-robin chooser holding rr_last and producing a one-hot select.
- The FSM, muxes and watchdog stay in the top module.

Test Plan:
- Single instruction read: m0_req, addr 0x100, mem_gnt in the same cycle, mem_rvalid 2 cycles later with 0x00000013 → m0_gnt 1 cycle, m0_rvalid with 0x00000013, m1 outputs all 0, mem_we=0, mem_be=1111.
- Simultaneous requests after reset: m0_req and m1_req together → master 0 is served first. Master 1 is granted in the first IDLE cycle after master 0's rvalid. A third simultaneous pair grants master 0 again (alternation).
- Grant stall: m1 write, addr 0x2000, wdata 0xCAFEF00D, mem_gnt held low 3 cycles while m0_req rises → mem_addr stays 0x2000 and mem_we=1 throughout; m0 is served only after m1's rvalid.
- Timeout: m0 read granted, mem_rvalid never comes, TIMEOUT_CYCLES=8 → m0_rvalid with 0xDEADBEEF occurs exactly 8 cycles after entering RESP, timeout_err=1 and stays high. A late mem_rvalid is ignored.
- Rvalid coincident with the last timeout cycle → real mem_rdata is delivered and timeout_err stays 0.
- Reset in RESP: res=0 for 1 cycle → the next cycle is IDLE, busy=0. A mem_rvalid that follows produces no m0_rvalid or m1_rvalid. The first tie after reset goes to master 0.
